// File: rtl/alu_seq_mdu.sv
// rtl/alu_seq_mdu.sv - handshaked ALU with registered result stage and optional iterative mul/div unit
// Build option: define ALU_MDU_EN to build the multiply/divide unit and the MBUSY state.
//   Without it, m=1 ops complete in one cycle with result 0 and normal flags.
// Ports:
//   clk, rst_n (async active-low), flush (sync abort of in-flight op and held result)
//   in_valid/in_ready : a, b, op = {m, funct7[5], funct3[2:0]}
//   out_valid/out_ready : result, eq, lt, ltu, zerof, negativef, carryf
module alu_seq_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            eq,
    output logic            lt,
    output logic            ltu,
    output logic            zerof,
    output logic            negativef,
    output logic            carryf
);

`ifdef ALU_MDU_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MBUSY = 2'd1, S_HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

    state_t state, state_n;
    logic   accept;
    logic   is_m;

    assign is_m   = op[4];
    assign accept = in_valid & in_ready;

    // Shared adder: result of ADD/SUB and source of zerof/negativef/carryf
    logic [XLEN-1:0] b_add;
    logic [XLEN:0]   sum_ext;
    logic [SHW-1:0]  shamt;
    logic            lt_c;
    logic            ltu_c;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] base_res;

    assign b_add   = op[3] ? ~b : b;
    assign sum_ext = {1'b0, a} + {1'b0, b_add} + {{XLEN{1'b0}}, op[3]};
    assign shamt   = b[SHW-1:0];
    assign lt_c    = $signed(a) < $signed(b);
    assign ltu_c   = a < b;
    // Kept as its own assignment so the shift stays arithmetic regardless of context
    assign sra_res = $signed(a) >>> shamt;

    always_comb begin
        base_res = '0;
        case (op[2:0])
            3'b000:  base_res = sum_ext[XLEN-1:0];
            3'b001:  base_res = a << shamt;
            3'b010:  base_res = {{(XLEN-1){1'b0}}, lt_c};
            3'b011:  base_res = {{(XLEN-1){1'b0}}, ltu_c};
            3'b100:  base_res = a ^ b;
            3'b101: begin
                if (op[3]) base_res = sra_res;
                else       base_res = a >> shamt;
            end
            3'b110:  base_res = a | b;
            default: base_res = a & b;
        endcase
    end

`ifdef ALU_MDU_EN
    // Iterative unit works on magnitudes; signs are applied in the final cycle.
    localparam logic [SHW:0] CNT_FIX = XLEN[SHW:0];

    logic [XLEN-1:0]   m_a;       // original dividend, needed for divide-by-zero remainder
    logic [XLEN-1:0]   m_b;       // magnitude of multiplicand / divisor
    logic [2:0]        m_f3;
    logic [2*XLEN-1:0] acc;       // {hi, lo}: product, or {remainder, quotient}
    logic [SHW:0]      cnt;
    logic              neg_q;     // negate product / quotient
    logic              neg_r;     // negate remainder (follows dividend)

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_sgn = op[2] ? ~op[0] : (op[1] ^ op[0]);
    assign b_sgn = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    assign a_neg = a_sgn & a[XLEN-1];
    assign b_neg = b_sgn & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    logic [XLEN:0]     mul_hi;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN:0]   div_sh;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;

    assign mul_hi    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & m_b};
    assign mul_next  = {mul_hi, acc[XLEN-1:1]};
    assign div_sh    = {acc, 1'b0};
    assign div_trial = div_sh[2*XLEN:XLEN] - {1'b0, m_b};
    // A non-negative trial means the divisor fits: keep difference, set quotient bit
    assign div_next  = div_trial[XLEN] ? div_sh[2*XLEN-1:0]
                                       : {div_trial[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic              div_zero;
    logic [XLEN-1:0]   mdu_res;

    assign prod     = neg_q ? -acc : acc;
    assign quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign div_zero = (m_b == '0);

    always_comb begin
        mdu_res = '0;
        case (m_f3)
            3'b000:                 mdu_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: mdu_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         mdu_res = div_zero ? '1 : quo;
            default:                mdu_res = div_zero ? m_a : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a   <= '0;
            m_b   <= '0;
            m_f3  <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept && is_m) begin
            // Accept cycle doubles as the setup cycle
            m_a   <= a;
            m_b   <= b_mag;
            m_f3  <= op[2:0];
            acc   <= {{XLEN{1'b0}}, a_mag};
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (state == S_MBUSY && !flush && cnt != CNT_FIX) begin
            acc <= m_f3[2] ? div_next : mul_next;
            cnt <= cnt + {{SHW{1'b0}}, 1'b1};
        end
    end
`endif

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: in_ready = ~flush;
            S_HOLD: begin
                out_valid = 1'b1;
                in_ready  = ~flush & out_ready;
            end
            default: ;
        endcase

        if (flush) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_HOLD: begin
                    if (in_valid && in_ready) begin
`ifdef ALU_MDU_EN
                        state_n = is_m ? S_MBUSY : S_HOLD;
`else
                        state_n = S_HOLD;
`endif
                    end else if (state == S_HOLD && out_ready) begin
                        state_n = S_IDLE;
                    end
                end
`ifdef ALU_MDU_EN
                S_MBUSY: if (cnt == CNT_FIX) state_n = S_HOLD;
`endif
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            result    <= '0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            ltu       <= 1'b0;
            zerof     <= 1'b0;
            negativef <= 1'b0;
            carryf    <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                eq        <= (a == b);
                lt        <= lt_c;
                ltu       <= ltu_c;
                zerof     <= ~|sum_ext[XLEN-1:0];
                negativef <= sum_ext[XLEN-1];
                carryf    <= sum_ext[XLEN];
`ifdef ALU_MDU_EN
                if (!is_m) result <= base_res;
`else
                result    <= is_m ? '0 : base_res;
`endif
            end
`ifdef ALU_MDU_EN
            else if (state == S_MBUSY && !flush && cnt == CNT_FIX) begin
                result <= mdu_res;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_mdu.sv
// tb/tb_alu_seq_mdu.sv - scoreboard testbench for alu_seq_mdu
`timescale 1ns/1ps
module tb_alu_seq_mdu;

`ifdef ALU_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [4:0]  op;
    logic        eq, lt, ltu, zerof, negativef, carryf;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, result8;
    logic [4:0]  op8;
    logic        eq8, lt8, ltu8, zerof8, negativef8, carryf8;

    alu_seq_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .eq(eq), .lt(lt), .ltu(ltu), .zerof(zerof), .negativef(negativef), .carryf(carryf)
    );

    alu_seq_mdu #(.XLEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .op(op8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .eq(eq8), .lt(lt8), .ltu(ltu8), .zerof(zerof8), .negativef(negativef8), .carryf(carryf8)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  flg;
    } exp_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [5:0]  flg;
    } vec_t;

    exp_t sb[$];
    vec_t bv [10];
    vec_t mv [9];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: result=%h with no pending expectation", result);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || {eq, lt, ltu, zerof, negativef, carryf} !== e.flg) begin
                    errors++;
                    $display("FAIL scoreboard: got result=%h flags=%b, expected result=%h flags=%b",
                             result, {eq, lt, ltu, zerof, negativef, carryf}, e.res, e.flg);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    function automatic logic [31:0] mr(input logic [31:0] v);
        return MDU ? v : 32'h0;
    endfunction

    task automatic send(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] er, input logic [5:0] ef, output int waited);
        int   n;
        exp_t e;
        n = 0;
        op = o; a = va; b = vb; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            step();
            #1;
            n++;
        end
        waited = n;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for op %b", o);
            in_valid = 1'b0;
        end else begin
            e.res = er;
            e.flg = ef;
            sb.push_back(e);
            step();
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int   w, n, acc_cyc, lat;
        logic bad;

        bv = '{
            '{5'b01101, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 6'b010001},
            '{5'b01101, 32'h80000000, 32'h00000000, 32'h80000000, 6'b010011},
            '{5'b00011, 32'h00000003, 32'hFFFFFFFF, 32'h00000001, 6'b001001},
            '{5'b00100, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000000, 6'b100011},
            '{5'b00001, 32'h00000001, 32'h00000025, 32'h00000020, 6'b011000},
            '{5'b00101, 32'h80000000, 32'h0000001F, 32'h00000001, 6'b010010},
            '{5'b00111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 6'b010001},
            '{5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 6'b010101},
            '{5'b01000, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 6'b011010},
            '{5'b00110, 32'h12340000, 32'h00005678, 32'h12345678, 6'b000000}
        };
        mv = '{
            '{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6'b011001},
            '{5'b10101, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 6'b000000},
            '{5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 6'b010010},
            '{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 6'b011001},
            '{5'b10000, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 6'b010001},
            '{5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6'b100011},
            '{5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'b100011},
            '{5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 6'b010010},
            '{5'b10111, 32'h00000064, 32'h00000007, 32'h00000002, 6'b000000}
        };

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_result", result, 0);
        chk("reset_flags", {eq, lt, ltu, zerof, negativef, carryf}, 0);

        // ADD overflow to zero: single-cycle valid pulse
        send(5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 6'b010101, w);
        chk("add_valid_next_cycle", out_valid, 1);
        step();
        chk("add_valid_one_cycle", out_valid, 0);

        // MULH latency and in_ready during busy
        send(5'b10001, 32'h80000000, 32'h80000000, mr(32'h40000000), 6'b100101, w);
        acc_cyc = cyc - 1;
        bad = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) bad = 1'b1;
            step();
            n++;
        end
        lat = cyc - acc_cyc;
        chk("mulh_latency", lat, MDU ? 34 : 1);
        chk("mulh_busy_in_ready", bad, 0);
        step();

        for (int i = 0; i < 10; i++)
            send(bv[i].op, bv[i].a, bv[i].b, bv[i].res, bv[i].flg, w);
        for (int i = 0; i < 9; i++)
            send(mv[i].op, mv[i].a, mv[i].b, mr(mv[i].res), mv[i].flg, w);
        n = 0;
        while (sb.size() != 0 && n < 100) begin step(); n++; end
        step();

        // Hold with out_ready low, then back-to-back transfer
        out_ready = 1'b0;
        send(5'b01000, 32'h5, 32'h7, 32'hFFFFFFFE, 6'b011010, w);
        op = 5'b00000; a = 32'h2; b = 32'h3; in_valid = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            #1;
            if (!out_valid || result !== 32'hFFFFFFFE || !lt || !negativef || in_ready) bad = 1'b1;
            step();
        end
        chk("hold_stable", bad, 0);
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        begin
            exp_t e;
            e.res = 32'h5;
            e.flg = 6'b011000;
            sb.push_back(e);
        end
        step();
        in_valid = 1'b0;
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_result", result, 32'h5);
        step();

        // Flush during DIVU iterations
        out_ready = 1'b0;
        op = 5'b10101; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        #1;
        chk("flush_pre_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        flush = 1'b1; in_valid = 1'b1; op = 5'b00000; a = 32'h1; b = 32'h1;
        #1;
        chk("flush_blocks_accept", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) bad = 1'b1;
        end
        chk("flush_no_valid", bad, 0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        op = 5'b10101; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {eq, lt, ltu, zerof, negativef, carryf}, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        send(5'b00000, 32'h2, 32'h3, 32'h5, 6'b011000, w);

        // 8-bit SRA
        op8 = 5'b01101; a8 = 8'h90; b8 = 8'h03; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        chk("sra8_valid", out_valid8, 1);
        chk("sra8_result", result8, 8'hF2);
        step();
        op8 = 5'b01101; a8 = 8'h80; b8 = 8'h07; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        chk("sra8_max_shift", result8, 8'hFF);

        n = 0;
        while (sb.size() != 0 && n < 100) begin step(); n++; end
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_mdu.md
Name: alu_seq_mdu

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU.
- Adds a registered result stage, valid/ready flow control, flush, correct arithmetic SRA for any width, and an iterative RV-M style multiply/divide unit.
- Sits between the register-read stage and the writeback stage of the core.
- Base ops complete in 1 cycle; M ops stall the pipe until done.

Parameters:
- XLEN, 32, datapath width; must be a power of two, 8 or more.
- SHW, $clog2(XLEN), shift-amount width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the in-flight op and any held result
- in_valid  in  1  operands/op offered
- in_ready  out  1  block accepts when in_valid&in_ready
- a  in  XLEN  operand A
- b  in  XLEN  operand B
- op  in  5  {m, funct7[5], funct3[2:0]}
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result when out_valid&out_ready
- result  out  XLEN  result
- eq, lt, ltu, zerof, negativef, carryf  out  1 each  flags registered with result

Behaviour:
- Reset: state IDLE; out_valid=0; result=0; all flags=0; in_ready=1.
- States:
  - IDLE: accept allowed.
  - MBUSY: iterative mul/div running.
  - HOLD: result valid, waiting for out_ready.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). A transfer in HOLD is back-to-back: result is replaced in the same cycle.
- Base ops (m=0): result registered 1 cycle after accept; state goes to HOLD.
  - funct3 map: 000 ADD/SUB (funct7[5]=1 subtracts via ~b + 1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - Shift amount is b[SHW-1:0].
  - SRA replicates a[XLEN-1] for every shamt, including 0 and XLEN-1.
- Flags (all ops): eq=(a==b); lt=signed a<b; ltu=unsigned a<b; zerof=~|sum; negativef=sum[XLEN-1]; carryf=adder carry-out. sum is the ADD/SUB result for funct7[5]. Flags are captured at accept.
- M ops (m=1, funct7[5] ignored):
  - funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Shift-add multiply / restoring divide on magnitudes: 1 setup cycle, XLEN iteration cycles, 1 sign-fixup cycle.
  - out_valid rises exactly XLEN+2 cycles after accept.
  - in_ready=0 throughout MBUSY.
- Division by zero: quotient = all ones; remainder = a.
- Signed overflow (a = -2^(XLEN-1), b = -1): DIV returns a; REM returns 0.
- HOLD: result and flags stable until out_ready. A new accept may not corrupt them before transfer.
- flush: highest priority after reset.
  - Next state IDLE; out_valid=0.
  - An in_valid in the same cycle is not accepted (in_ready forced 0 while flush=1).
- Async reset mid-MBUSY: abandons immediately; outputs return to reset values.

Optional Feature:
- ALU_MDU_EN defined: M ops behave as above.
- ALU_MDU_EN undefined:
  - MDU logic and the MBUSY state are not built.
  - Any op with m=1 completes in 1 cycle with result=0 and flags computed normally.
  - Every op then has fixed 1-cycle latency.

Test Plan:
- XLEN=32, ADD a=0xFFFFFFFF b=1, out_ready=1 -> next cycle result=0, zerof=1, carryf=1, out_valid for 1 cycle.
- SRA a=0x80000000 b=31 -> 0xFFFFFFFF. Same op with b=0 -> 0x80000000. XLEN=8: SRA a=0x90 b=3 -> 0xF2.
- ALU_MDU_EN, MULH a=0x80000000 b=0x80000000 -> out_valid exactly 34 cycles after accept; result=0x40000000; in_ready=0 during busy.
- DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000. DIVU a=7 b=0 -> 0xFFFFFFFF. REM a=-7 b=2 -> 0xFFFFFFFF (-1).
- out_ready=0 for 5 cycles after SUB 5-7 -> result 0xFFFFFFFE held with lt=1, negativef=1. Raise out_ready with a new in_valid -> back-to-back accept, next result the following cycle.
- flush at iteration 10 of DIVU -> out_valid never rises, in_ready=1 next cycle. Repeat with rst_n pulsed low mid-op -> all outputs 0 asynchronously.
